// File: rtl/scan_chain_controller.sv
// Serial driver/unloader for a single scan chain: loads a parallel pattern MSB-first,
// unloads the previous chain contents, optionally runs a capture phase, returns the response.
module scan_chain_controller #(
  parameter int CHAIN_LEN      = 8,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic                 pat_capture,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [CHAIN_LEN-1:0] resp_data,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 busy
);

  localparam int MAX_CNT = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CAP_LAST   = CW'((CAPTURE_CYCLES > 0) ? CAPTURE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam bit            CAP_EN     = (CAPTURE_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               state_reg;
  logic [CW-1:0]        cnt_reg;
  logic [CHAIN_LEN-1:0] pat_sr_reg;
  logic [CHAIN_LEN-1:0] resp_sr_reg;
  logic                 cap_flag_reg;
  logic                 pat_ready_reg;
  logic                 scan_en_reg;
  logic                 scan_in_reg;
  logic                 resp_valid_reg;
  logic                 busy_reg;

  // Outputs are registered alongside the state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      pat_sr_reg     <= '0;
      resp_sr_reg    <= '0;
      cap_flag_reg   <= 1'b0;
      pat_ready_reg  <= 1'b1;
      scan_en_reg    <= 1'b0;
      scan_in_reg    <= 1'b0;
      resp_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pat_valid) begin
            pat_sr_reg    <= pat_data;
            cap_flag_reg  <= pat_capture;
            cnt_reg       <= '0;
            state_reg     <= SHIFT;
            pat_ready_reg <= 1'b0;
            scan_en_reg   <= 1'b1;
            scan_in_reg   <= pat_data[CHAIN_LEN-1];
            busy_reg      <= 1'b1;
          end
        end

        SHIFT: begin
          pat_sr_reg  <= {pat_sr_reg[CHAIN_LEN-2:0], 1'b0};
          resp_sr_reg <= {resp_sr_reg[CHAIN_LEN-2:0], scan_out};
          if (cnt_reg == SHIFT_LAST) begin
            cnt_reg     <= '0;
            scan_en_reg <= 1'b0;
            scan_in_reg <= 1'b0;
            if (cap_flag_reg && CAP_EN) begin
              state_reg <= CAPTURE;
            end else begin
              state_reg      <= DONE;
              resp_valid_reg <= 1'b1;
            end
          end else begin
            cnt_reg     <= cnt_reg + CNT_ONE;
            // Pre-load the bit that becomes the MSB after this edge's shift.
            scan_in_reg <= pat_sr_reg[CHAIN_LEN-2];
          end
        end

        CAPTURE: begin
          if (cnt_reg == CAP_LAST) begin
            cnt_reg        <= '0;
            state_reg      <= DONE;
            resp_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        DONE: begin
          if (resp_ready) begin
            state_reg      <= IDLE;
            resp_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            pat_ready_reg  <= 1'b1;
          end
        end

        default: begin
          state_reg      <= IDLE;
          cnt_reg        <= '0;
          pat_ready_reg  <= 1'b1;
          scan_en_reg    <= 1'b0;
          scan_in_reg    <= 1'b0;
          resp_valid_reg <= 1'b0;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign pat_ready  = pat_ready_reg;
  assign scan_en    = scan_en_reg;
  assign scan_in    = scan_in_reg;
  assign resp_valid = resp_valid_reg;
  assign busy       = busy_reg;
  // resp_sr only moves during SHIFT, so it is stable for the whole DONE phase.
  assign resp_data  = resp_sr_reg;

endmodule

// File: tb/tb_scan_chain_controller.sv
// Scoreboard bench for scan_chain_controller driving an 8-flop scan_register model;
// expected responses are queued at pattern accept and compared at response handshake.
module tb_scan_chain_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       pat_valid;
  logic       pat_ready;
  logic [7:0] pat_data;
  logic       pat_capture;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_data;
  logic       scan_en;
  logic       scan_in;
  logic       scan_out;
  logic       busy;
  logic [7:0] data_in;
  logic [7:0] chain;

  int         vectors     = 0;
  int         miscompares = 0;
  int         resp_count  = 0;
  logic [7:0] sb_q[$];
  logic [7:0] chain_exp;
  logic [7:0] mon_exp;

  logic [7:0] burst_pat[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic       burst_cap[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int         acc_cyc[4];

  always #5 clk = ~clk;

  scan_chain_controller #(.CHAIN_LEN(8), .CAPTURE_CYCLES(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .pat_valid   (pat_valid),
    .pat_ready   (pat_ready),
    .pat_data    (pat_data),
    .pat_capture (pat_capture),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .scan_en     (scan_en),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .busy        (busy)
  );

  // Scan register model: shifts on scan_en, loads data_in only during the capture phase.
  assign scan_out = chain[7];
  always @(posedge clk) begin
    if (rst)                             chain <= 8'h00;
    else if (scan_en)                    chain <= {chain[6:0], scan_in};
    else if (busy && !resp_valid)        chain <= data_in;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        resp_count++;
        $display("resp %0d: data=%02h expected=%02h", resp_count, resp_data, mon_exp);
        chk("resp_data", {24'd0, resp_data}, {24'd0, mon_exp});
      end
    end
  end

  task automatic send(input logic [7:0] p, input logic c, input int stall);
    int cyc, n_shift, n_cap;
    logic [7:0] held;
    cyc = 0;
    while (!pat_ready && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("pat_ready_idle", {31'd0, pat_ready}, 32'd1);
    pat_data    = p;
    pat_capture = c;
    pat_valid   = 1'b1;
    sb_q.push_back(chain_exp);
    chain_exp = c ? data_in : p;
    @(posedge clk); #1;
    pat_valid = 1'b0;
    n_shift = 0;
    n_cap   = 0;
    cyc     = 0;
    while (!resp_valid && cyc < 30) begin
      chk("pat_ready_busy", {31'd0, pat_ready}, 32'd0);
      chk("busy_high", {31'd0, busy}, 32'd1);
      if (scan_en) begin
        if (n_shift < 8) chk("scan_in", {31'd0, scan_in}, {31'd0, p[7-n_shift]});
        n_shift++;
      end else begin
        n_cap++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    chk("shift_cycles", n_shift, 32'd8);
    chk("capture_cycles", n_cap, c ? 32'd1 : 32'd0);
    held = resp_data;
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", {31'd0, resp_valid}, 32'd1);
      chk("stall_data", {24'd0, resp_data}, {24'd0, held});
      chk("stall_pat_ready", {31'd0, pat_ready}, 32'd0);
      chk("stall_scan_en", {31'd0, scan_en}, 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("post_valid", {31'd0, resp_valid}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("post_pat_ready", {31'd0, pat_ready}, 32'd1);
  endtask

  initial begin
    int k, t;
    rst         = 1'b1;
    pat_valid   = 1'b0;
    pat_data    = 8'h00;
    pat_capture = 1'b0;
    resp_ready  = 1'b0;
    data_in     = 8'h00;
    chain_exp   = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_pat_ready", {31'd0, pat_ready}, 32'd1);
    chk("rst_scan_en", {31'd0, scan_en}, 32'd0);
    chk("rst_scan_in", {31'd0, scan_in}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", {24'd0, resp_data}, 32'd0);

    send(8'hA5, 1'b0, 0);
    chk("chain_a5", {24'd0, chain}, 32'hA5);
    send(8'h3C, 1'b0, 0);
    chk("chain_3c", {24'd0, chain}, 32'h3C);

    data_in = 8'h5A;
    send(8'hFF, 1'b1, 0);
    chk("chain_captured", {24'd0, chain}, 32'h5A);
    send(8'h00, 1'b0, 0);

    send(8'h96, 1'b0, 5);

    // Abort a shift after three shift edges.
    pat_data    = 8'hC3;
    pat_capture = 1'b0;
    pat_valid   = 1'b1;
    @(posedge clk); #1;
    pat_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_scan_en", {31'd0, scan_en}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_pat_ready", {31'd0, pat_ready}, 32'd1);
    sb_q.delete();
    chain_exp = 8'h00;
    send(8'h81, 1'b0, 0);
    chk("chain_81", {24'd0, chain}, 32'h81);

    // Back-to-back with pat_valid and resp_ready held high.
    data_in    = 8'h77;
    pat_valid  = 1'b1;
    resp_ready = 1'b1;
    k = 0;
    t = 0;
    while (k < 4 && t < 200) begin
      if (pat_ready) begin
        pat_data    = burst_pat[k];
        pat_capture = burst_cap[k];
        sb_q.push_back(chain_exp);
        chain_exp  = burst_cap[k] ? data_in : burst_pat[k];
        acc_cyc[k] = t;
        k++;
      end
      @(posedge clk); #1;
      t++;
    end
    pat_valid = 1'b0;
    chk("burst_accepts", k, 32'd4);
    while (sb_q.size() > 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    resp_ready = 1'b0;
    chk("period_cap", acc_cyc[1] - acc_cyc[0], 32'd11);
    chk("period_nocap", acc_cyc[2] - acc_cyc[1], 32'd10);
    chk("period_cap2", acc_cyc[3] - acc_cyc[2], 32'd11);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 32'd0);
    chk("resp_count", resp_count, 32'd10);
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scan_chain_controller.md
Name: scan_chain_controller

Overview:
Serial driver and unloader for one scan_register chain of CHAIN_LEN flops.
- Accepts a parallel test pattern over a valid/ready handshake.
- Shifts the pattern MSB-first into the chain while collecting the old chain contents from scan_out.
- Optionally holds scan_en low for CAPTURE_CYCLES so the chain loads its functional data_in.
- Returns the unloaded response over a second valid/ready handshake.
- Sits directly upstream of scan_register, driving its scan_en/scan_in and consuming its scan_out.

Parameters:
CHAIN_LEN, 8, number of flops in the attached chain; must be >= 2.
CAPTURE_CYCLES, 1, cycles with scan_en=0 after a shift when capture is requested; 0 = capture never occurs.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  reset; synchronous, active-high.
pat_valid  input  1  pattern offered.
pat_ready  output  1  controller can accept a pattern.
pat_data  input  CHAIN_LEN  pattern; bit i ends in chain flop i.
pat_capture  input  1  sampled with pat_data; 1 = run capture phase after the shift.
resp_valid  output  1  response available.
resp_ready  input  1  response consumer ready.
resp_data  output  CHAIN_LEN  chain contents unloaded during the shift; bit i = chain flop i before the shift.
scan_en  output  1  to chain; 1 = shift.
scan_in  output  1  serial data to chain.
scan_out  input  1  serial data from chain MSB.
busy  output  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, SHIFT, CAPTURE, DONE. All outputs are Moore outputs decoded from registered state and datapath.
- Reset (rst=1 at a clk edge) forces the following, overriding any activity including a mid-operation shift. The chain contents are then undefined.
  - State IDLE, counter 0.
  - Pattern and response shift registers zeroed.
  - resp_valid=0, scan_en=0, scan_in=0, busy=0.
  - pat_ready=1 from the first cycle after reset.
- IDLE:
  - pat_ready=1, scan_en=0, scan_in=0.
  - An edge with pat_valid=1 latches pat_data into pat_sr and pat_capture into cap_flag, clears the counter, and moves to SHIFT.
- SHIFT (exactly CHAIN_LEN cycles):
  - scan_en=1, scan_in=pat_sr[CHAIN_LEN-1].
  - Each edge: pat_sr shifts left by 1 (zero fill), resp_sr <= {resp_sr[CHAIN_LEN-2:0], scan_out}, counter increments.
  - On the edge where counter==CHAIN_LEN-1: go to CAPTURE if cap_flag=1 and CAPTURE_CYCLES>0, otherwise DONE. Clear the counter.
- CAPTURE (exactly CAPTURE_CYCLES cycles):
  - scan_en=0, scan_in=0.
  - On the edge where counter==CAPTURE_CYCLES-1, go to DONE.
- DONE:
  - resp_valid=1, resp_data=resp_sr, held stable until handshake.
  - An edge with resp_ready=1 goes to IDLE. resp_valid drops the next cycle.
  - resp_ready=0 stalls indefinitely with scan_en=0.
- pat_ready is 1 only in IDLE. pat_valid outside IDLE is ignored. resp_ready outside DONE is ignored.
- Latency from pattern accept edge:
  - scan_en rises next cycle.
  - resp_valid rises CHAIN_LEN (+CAPTURE_CYCLES if capturing) cycles after scan_en rises.
  - Minimum back-to-back period is CHAIN_LEN+C+2 cycles.
- Counter width is $clog2(max(CHAIN_LEN, CAPTURE_CYCLES)+1). No wrap is possible within a phase.

Test Plan:
Bench: CHAIN_LEN=8, CAPTURE_CYCLES=1; DUT drives an 8-bit scan_register whose data_in is set by the bench.
1. After reset, offer pattern 0xA5 with pat_capture=0 -> scan_en high for exactly 8 cycles, scan_in sequence 1,0,1,0,0,1,0,1; resp_data=0x00; chain then holds 0xA5.
2. Follow with pattern 0x3C, pat_capture=0 -> resp_data=0xA5; chain holds 0x3C; pat_ready low for the whole operation.
3. Set data_in=0x5A; offer 0xFF with pat_capture=1 -> 8 shift cycles then 1 cycle with scan_en=0; resp_data=0x3C. Then offer 0x00, pat_capture=0 -> resp_data=0x5A.
4. Hold resp_ready=0 for 5 cycles in DONE -> resp_valid=1 and resp_data constant throughout, pat_ready=0, scan_en=0. Release -> IDLE the next cycle.
5. Assert rst after 3 shift cycles -> the next cycle has scan_en=0, busy=0, resp_valid=0, pat_ready=1. A fresh 0x81 shift then completes normally in 8 cycles.
6. Hold pat_valid=1 continuously -> a new pattern is accepted on the first IDLE cycle after each resp handshake; period is 11 cycles with capture and 10 without.
